// File: rtl/tape_pulse_player.sv
// Drains the tape FIFO as 16-bit little-endian pulse durations and rebuilds
// the EAR square wave by toggling a level after each duration expires.
module tape_pulse_player #(
  parameter int unsigned TICK_DIV = 123
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rd,
  output logic       ear_out,
  output logic       busy,
  output logic       underrun,
  output logic       block_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_CAP_LO,
    S_RD_HI,
    S_CAP_HI,
    S_COUNT
  } state_t;

  localparam logic [7:0] PSC_LAST = 8'(TICK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_dur_lo;
  logic [15:0] r_cnt;
  logic [7:0]  r_psc;
  logic        r_ear;
  logic        r_done;
  logic        w_rd;
  logic        w_underrun;
  logic [15:0] w_dur;
  logic        w_end_marker;

  assign w_dur        = {fifo_q, r_dur_lo};
  assign w_end_marker = (w_dur == 16'h0000);

  // Handshake: fifo_rd is a single-cycle strobe issued only while the FIFO
  // reports data; the byte it fetches is captured on the following cycle.
  always_comb begin
    w_next     = r_state;
    w_rd       = 1'b0;
    w_underrun = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !fifo_empty) w_next = S_RD_LO;
      end
      S_RD_LO: begin
        if (enable && !fifo_empty) begin
          w_rd   = 1'b1;
          w_next = S_CAP_LO;
        end else if (enable) begin
          w_underrun = 1'b1;
        end
      end
      S_CAP_LO: w_next = S_RD_HI;
      S_RD_HI: begin
        if (enable && !fifo_empty) begin
          w_rd   = 1'b1;
          w_next = S_CAP_HI;
        end else if (fifo_empty) begin
          w_underrun = 1'b1;
        end
      end
      S_CAP_HI: w_next = w_end_marker ? S_IDLE : S_COUNT;
      S_COUNT: begin
        if (enable && (r_psc == PSC_LAST) && (r_cnt == 16'd1)) w_next = S_RD_LO;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dur_lo <= 8'd0;
      r_cnt    <= 16'd0;
      r_psc    <= 8'd0;
      r_ear    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_CAP_LO: r_dur_lo <= fifo_q;
        S_CAP_HI: begin
          if (w_end_marker) begin
            r_ear  <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_cnt <= w_dur;
            r_psc <= 8'd0;
          end
        end
        S_COUNT: begin
          // Pausing freezes both the prescaler and the tick counter.
          if (enable) begin
            if (r_psc == PSC_LAST) begin
              r_psc <= 8'd0;
              r_cnt <= r_cnt - 16'd1;
              if (r_cnt == 16'd1) r_ear <= ~r_ear;
            end else begin
              r_psc <= r_psc + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_rd    = w_rd & ~reset;
  assign underrun   = w_underrun & ~reset;
  assign busy       = (r_state != S_IDLE);
  assign ear_out    = r_ear;
  assign block_done = r_done;

endmodule
